uart_rx_msg_bridge: RTL and testbench

//  Byte-to-frame bridge between a UART byte receiver and a message controller.

---
 rtl/uart_bridge_pkg.sv | 16 +
 rtl/uart_byte_collector.sv | 51 +++++
 rtl/uart_rx_msg_bridge.sv | 139 +++++++++++++
 tb/tb_uart_rx_msg_bridge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared types and constants for the UART byte-to-frame bridge
// Contents:
//   bridge_state_t : frame FSM states (IDLE, HEADER, BODY, HOLD)
//   START_BYTE     : byte that opens a frame when seen in IDLE
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BODY,
        HOLD
    } bridge_state_t;

    localparam logic [7:0] START_BYTE = 8'hBB;

endpackage

// File: rtl/uart_byte_collector.sv
// rtl/uart_byte_collector.sv - packs a byte stream LSB-first into a WIDTH-bit register
// Ports:
//   clk_in    in   1      clock, rising edge
//   rst_in    in   1      asynchronous active-low reset; clears count and data
//   i_clear   in   1      restart the fill at byte 0 (data is kept)
//   i_strobe  in   1      i_byte is to be stored this cycle
//   i_byte    in   8      byte to store
//   o_data    out  WIDTH  assembled register, byte k at [8k+:8]
//   o_done    out  1      high on the strobe that writes the last byte
module uart_byte_collector #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH / 8) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_clear,
    input  logic             i_strobe,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_data,
    output logic             o_done
);

    localparam int NB = WIDTH / 8;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_data;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(NB - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_count <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_strobe) begin
            // Restart at 0 after the last byte so the next frame needs no extra clear.
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
            for (int k = 0; k < NB; k++) begin
                if (r_count == CNT_W'(k)) begin
                    r_data[8*k +: 8] <= i_byte;
                end
            end
        end
    end

    assign o_data = r_data;
    assign o_done = i_strobe && !i_clear && w_last;

endmodule

// File: rtl/uart_rx_msg_bridge.sv
// rtl/uart_rx_msg_bridge.sv - UART byte stream to parallel header/payload frame bridge
// Waits for START_BYTE, collects HEADER_SIZE bits of header then MESSAGE_SIZE bits of
// payload (LSB-first), then holds the frame with bdge_valid_out until ctrl_ready_in.
// Optional inter-byte timeout: define UART_RX_BRIDGE_TIMEOUT_EN.
// Ports:
//   clk_in          in   1             clock, rising edge
//   rst_in          in   1             asynchronous active-low reset
//   ll_byte_in      in   8             byte from UART receiver
//   ll_valid_in     in   1             byte strobe
//   ll_ready_out    out  1             bridge accepts a byte (low only in HOLD)
//   header_out      out  HEADER_SIZE   assembled header
//   message_out     out  MESSAGE_SIZE  assembled payload
//   bdge_valid_out  out  1             complete frame present
//   ctrl_ready_in   in   1             controller takes the frame
module uart_rx_msg_bridge #(
    parameter int MESSAGE_SIZE   = 512,
    parameter int HEADER_SIZE    = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [7:0]              ll_byte_in,
    input  logic                    ll_valid_in,
    output logic                    ll_ready_out,
    output logic [HEADER_SIZE-1:0]  header_out,
    output logic [MESSAGE_SIZE-1:0] message_out,
    output logic                    bdge_valid_out,
    input  logic                    ctrl_ready_in
);

    import uart_bridge_pkg::*;

    localparam int MAX_SIZE = (HEADER_SIZE > MESSAGE_SIZE) ? HEADER_SIZE : MESSAGE_SIZE;
    localparam int CNT_W    = $clog2(MAX_SIZE / 8) + 1;

    bridge_state_t r_state;
    bridge_state_t w_next;
    logic          w_accept;
    logic          w_hdr_done;
    logic          w_msg_done;
    logic          w_clear;
    logic          w_timeout;

    assign ll_ready_out   = (r_state != HOLD);
    assign bdge_valid_out = (r_state == HOLD);
    assign w_accept       = ll_valid_in && ll_ready_out;
    // Fill counters sit at 0 while idle, so a start byte always begins a fresh frame.
    assign w_clear        = (r_state == IDLE) || w_timeout;

    uart_byte_collector #(
        .WIDTH (HEADER_SIZE),
        .CNT_W (CNT_W)
    ) u_hdr (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_clear  (w_clear),
        .i_strobe (w_accept && (r_state == HEADER)),
        .i_byte   (ll_byte_in),
        .o_data   (header_out),
        .o_done   (w_hdr_done)
    );

    uart_byte_collector #(
        .WIDTH (MESSAGE_SIZE),
        .CNT_W (CNT_W)
    ) u_msg (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_clear  (w_clear),
        .i_strobe (w_accept && (r_state == BODY)),
        .i_byte   (ll_byte_in),
        .o_data   (message_out),
        .o_done   (w_msg_done)
    );

`ifdef UART_RX_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_idle_cnt;
    logic            w_collecting;

    assign w_collecting = (r_state == HEADER) || (r_state == BODY);
    assign w_timeout    = w_collecting && (r_idle_cnt >= TO_W'(TIMEOUT_CYCLES));

    // Counts idle clocks between accepted bytes; HOLD and IDLE keep it at 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_idle_cnt <= '0;
        end else if (w_collecting && !w_accept && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    // Never true; keeps TIMEOUT_CYCLES referenced when the timeout is not built.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && (ll_byte_in == START_BYTE)) begin
                    w_next = HEADER;
                end
            end
            HEADER: begin
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (w_hdr_done) begin
                    w_next = BODY;
                end
            end
            BODY: begin
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (w_msg_done) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (ctrl_ready_in) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_msg_bridge.sv
// tb/tb_uart_rx_msg_bridge.sv - self-checking bench for uart_rx_msg_bridge
module tb_uart_rx_msg_bridge;

    localparam int HS = 32;
    localparam int MS = 512;
    localparam int HB = HS / 8;
    localparam int MB = MS / 8;
    localparam int TO = 40;

    typedef logic [7:0] byte_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    ll_byte;
    logic          ll_valid;
    logic          ll_ready;
    logic [HS-1:0] hdr_o;
    logic [MS-1:0] msg_o;
    logic          bvalid;
    logic          ctrl_ready;

    int n_checks = 0;
    int n_err    = 0;

    byte_t         q[$];
    logic [HS-1:0] exp_h;
    logic [MS-1:0] exp_m;
    logic [HS-1:0] h;
    logic [MS-1:0] m;

    always #5 clk = ~clk;

    uart_rx_msg_bridge #(
        .MESSAGE_SIZE   (MS),
        .HEADER_SIZE    (HS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .ll_byte_in     (ll_byte),
        .ll_valid_in    (ll_valid),
        .ll_ready_out   (ll_ready),
        .header_out     (hdr_o),
        .message_out    (msg_o),
        .bdge_valid_out (bvalid),
        .ctrl_ready_in  (ctrl_ready)
    );

    task automatic chk(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte_t b, input int gap);
        ll_byte  = b;
        ll_valid = 1'b1;
        @(posedge clk);
        #1;
        ll_valid = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    // Sends q[0..n-1]; the final byte sent has no trailing gap.
    task automatic send_q(input int n, input int gap);
        for (int i = 0; i < n; i++) send_byte(q[i], (i == n - 1) ? 0 : gap);
    endtask

    task automatic handshake();
        ctrl_ready = 1'b1;
        @(posedge clk);
        #1;
        ctrl_ready = 1'b0;
    endtask

    function automatic logic [MS-1:0] rand_msg();
        logic [MS-1:0] r;
        for (int k = 0; k < MS / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Byte stream: njunk non-start bytes, start byte, header bytes, payload bytes.
    task automatic build(input logic [HS-1:0] hh, input logic [MS-1:0] mm, input int njunk);
        byte_t b;
        q.delete();
        for (int i = 0; i < njunk; i++) begin
            b = byte_t'($urandom);
            if (b == 8'hBB) b = 8'h3C;
            q.push_back(b);
        end
        q.push_back(8'hBB);
        for (int k = 0; k < HB; k++) q.push_back(hh[8*k +: 8]);
        for (int k = 0; k < MB; k++) q.push_back(mm[8*k +: 8]);
    endtask

    // Reference: skip to the first start byte, then the next HB bytes form the
    // header and the following MB bytes the payload, each placed LSB-first.
    function automatic void model(input byte_t s[$], output logic [HS-1:0] eh, output logic [MS-1:0] em);
        int p = 0;
        eh = '0;
        em = '0;
        while (p < s.size() && s[p] != 8'hBB) p++;
        p++;
        for (int k = 0; k < HB; k++) eh[8*k +: 8] = s[p + k];
        for (int k = 0; k < MB; k++) em[8*k +: 8] = s[p + HB + k];
    endfunction

    initial begin
        rst_n      = 1'b0;
        ll_byte    = 8'h00;
        ll_valid   = 1'b0;
        ctrl_ready = 1'b0;
        tick(3);
        chk("reset_hdr", MS'(hdr_o), '0);
        chk("reset_msg", msg_o, '0);
        chk("reset_valid", MS'(bvalid), '0);
        chk("reset_ready", MS'(ll_ready), MS'(1));
        rst_n = 1'b1;
        tick(2);

        // 1) fixed frame, one byte per 9 clocks, late controller
        h = 32'hFAFA_FAFA;
        m = {8{64'h0123456789abcdef}};
        build(h, m, 0);
        model(q, exp_h, exp_m);
        send_q(q.size(), 8);
        chk("t1_valid_latency", MS'(bvalid), MS'(1));
        tick(20);
        chk("t1_valid_held", MS'(bvalid), MS'(1));
        chk("t1_ready_low_hold", MS'(ll_ready), '0);
        chk("t1_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t1_msg", msg_o, exp_m);
        handshake();
        chk("t1_valid_after_hs", MS'(bvalid), '0);
        tick(5);
        chk("t1_hdr_stable", MS'(hdr_o), MS'(exp_h));
        chk("t1_msg_stable", msg_o, exp_m);

        // 2) second fixed frame
        chk("t2_ready_back", MS'(ll_ready), MS'(1));
        h = 32'hBCBC_BCBC;
        m = {8{64'hfedcba9876543210}};
        build(h, m, 0);
        model(q, exp_h, exp_m);
        send_q(q.size(), 2);
        chk("t2_valid", MS'(bvalid), MS'(1));
        chk("t2_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t2_msg", msg_o, exp_m);
        handshake();
        chk("t2_ready", MS'(ll_ready), MS'(1));

        // 3) junk before the start byte
        build(HS'($urandom), rand_msg(), 3);
        q.push_front(8'h55);
        q.push_front(8'h00);
        model(q, exp_h, exp_m);
        send_q(q.size(), 1);
        chk("t3_valid", MS'(bvalid), MS'(1));
        chk("t3_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t3_msg", msg_o, exp_m);
        handshake();

        // 4) controller always ready: valid is a single-clock pulse
        ctrl_ready = 1'b1;
        build(HS'($urandom), rand_msg(), 0);
        model(q, exp_h, exp_m);
        send_q(q.size() - 1, 1);
        tick(1);
        chk("t4_valid_before_last", MS'(bvalid), '0);
        send_byte(q[q.size() - 1], 0);
        chk("t4_valid_pulse", MS'(bvalid), MS'(1));
        chk("t4_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t4_msg", msg_o, exp_m);
        tick(1);
        chk("t4_valid_gone", MS'(bvalid), '0);
        chk("t4_ready", MS'(ll_ready), MS'(1));
        ctrl_ready = 1'b0;

        // 5) bytes offered during HOLD are dropped
        build(HS'($urandom), rand_msg(), 0);
        model(q, exp_h, exp_m);
        send_q(q.size(), 1);
        send_byte(8'hBB, 1);
        for (int i = 0; i < 6; i++) send_byte(byte_t'($urandom), 1);
        chk("t5_valid_held", MS'(bvalid), MS'(1));
        chk("t5_hdr_kept", MS'(hdr_o), MS'(exp_h));
        chk("t5_msg_kept", msg_o, exp_m);
        handshake();
        build(HS'($urandom), rand_msg(), 0);
        model(q, exp_h, exp_m);
        send_q(q.size(), 0);
        chk("t5_next_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t5_next_msg", msg_o, exp_m);
        handshake();

        // 6) asynchronous reset mid-payload
        build(HS'($urandom), rand_msg(), 0);
        send_q(1 + HB + 30, 1);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_hdr", MS'(hdr_o), '0);
        chk("t6_rst_msg", msg_o, '0);
        chk("t6_rst_valid", MS'(bvalid), '0);
        chk("t6_rst_ready", MS'(ll_ready), MS'(1));
        tick(1);
        rst_n = 1'b1;
        tick(1);
        build(HS'($urandom), rand_msg(), 2);
        model(q, exp_h, exp_m);
        send_q(q.size(), 1);
        chk("t6_after_hdr", MS'(hdr_o), MS'(exp_h));
        chk("t6_after_msg", msg_o, exp_m);
        handshake();

`ifdef UART_RX_BRIDGE_TIMEOUT_EN
        // stall mid-header longer than the timeout
        send_byte(8'hBB, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        tick(TO + 10);
        chk("to_valid", MS'(bvalid), '0);
        chk("to_ready", MS'(ll_ready), MS'(1));
        build(HS'($urandom), rand_msg(), 0);
        model(q, exp_h, exp_m);
        send_q(q.size(), 1);
        chk("to_frame_valid", MS'(bvalid), MS'(1));
        chk("to_frame_hdr", MS'(hdr_o), MS'(exp_h));
        chk("to_frame_msg", msg_o, exp_m);
        handshake();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
